serial_magnitude_comparator: RTL and testbench
==============================================

SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 4, bits compared per cycle; SHALL divide WIDTH exactly; NDIG = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request; sampled only when the block is idle or in its done cycle.
REQ-006 opA  input  WIDTH  operand A; captured on the accepting edge.
REQ-007 opB  input  WIDTH  operand B; captured on the accepting edge.
REQ-008 sel  input  3  relation: 000 EQ, 001 NE, 010 LT, 011 LE, 100 GT, 101 GE, 11x reserved; captured with operands.
REQ-009 signed_cmp  input  1  1 = two's-complement compare, 0 = unsigned; captured with operands.
REQ-010 busy  output  1  high while digits are being scanned.
REQ-011 done  output  1  one-cycle pulse: result valid.
REQ-012 res  output  1  outcome of the selected relation.
REQ-013 eq, lt, gt  output  1 each  raw relation flags; exactly one SHALL be high after any completed compare.

Function
REQ-014 FSM states SHALL be IDLE, SCAN, FIN; busy = (state == SCAN); done = (state == FIN).
REQ-015 IDLE or FIN with start = 1: capture opA, opB, sel, signed_cmp; digit index = NDIG-1 (MSB digit); next state SCAN.
REQ-016 FIN with start = 0 -> IDLE; IDLE with start = 0 -> IDLE.
REQ-017 Signed mode SHALL invert the MSB of both captured operands at capture; the scan is then unsigned.
REQ-018 SCAN, per edge: compare the current DIGIT-bit slice of A and B; if unequal, register lt/gt from that slice, eq = 0, go FIN (early exit).
REQ-019 SCAN, equal slice at index 0: register eq = 1, lt = gt = 0, go FIN; equal slice at index > 0: decrement index, stay SCAN.
REQ-020 Latency: with D = number of digits examined (1..NDIG), done SHALL be high in the cycle after edge D, counting the accepting edge as edge 0; worst case NDIG+1 cycles from start to done.
REQ-021 res SHALL be registered together with the flags: EQ = eq, NE = !eq, LT = lt, LE = lt|eq, GT = gt, GE = gt|eq, reserved = 0.
REQ-022 res, eq, lt, gt SHALL hold their values from FIN until the next completed compare; they SHALL NOT change during SCAN.
REQ-023 start while busy = 1 SHALL be ignored; opA/opB/sel/signed_cmp changes during SCAN SHALL NOT affect the result.
REQ-024 start in the FIN cycle SHALL be accepted (back-to-back); done SHALL still pulse for exactly one cycle for the previous compare.

Reset
REQ-025 rst_n = 0 at a rising edge SHALL force IDLE, busy = 0, done = 0, res = 0, eq = 0, lt = 0, gt = 0, and clear captured operands.
REQ-026 Reset during SCAN or FIN SHALL abort the compare; no done pulse SHALL follow for the aborted compare.
REQ-027 start SHALL be ignored on any edge where rst_n = 0.

Verification (WIDTH=16, DIGIT=4)
REQ-028 Unsigned LT, early exit: opA=0x1234, opB=0x1240, sel=010, signed_cmp=0 -> D=3, done after edge 3, res=1, lt=1, eq=gt=0.
REQ-029 Full scan equality: opA=opB=0xBEEF, sel=000 -> D=4, done after edge 4, res=1, eq=1; repeated with sel=001 -> res=0.
REQ-030 Signed vs unsigned: opA=0xFFFF, opB=0x0001, sel=010; signed_cmp=1 -> D=1, res=1, lt=1; signed_cmp=0 -> D=1, res=0, gt=1.
REQ-031 Handshake: start with opA=0x0000, opB=0xFFFF; assert start again with new operands while busy -> ignored, first result unchanged; assert start in the FIN cycle -> accepted, busy after next edge, one done per compare.
REQ-032 Reset mid-operation: start with opA=opB=0x5555; drive rst_n=0 after edge 2 -> next edge IDLE, all outputs 0, no done pulse.
REQ-033 Reserved selector: opA=0x0001, opB=0x0002, sel=110 -> done after edge 4, res=0, lt=1.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Serial magnitude comparator: scans two captured operands DIGIT bits per
// cycle from the most significant digit and stops at the first differing
// digit. Signed compares bias both operands (MSB flip) so the scan itself is
// always unsigned.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              request, accepted in IDLE or in the done cycle
//   opA, opB           operands, captured on the accepting edge
//   sel                relation: EQ/NE/LT/LE/GT/GE, 11x reserved (res = 0)
//   signed_cmp         1 = two's-complement compare
//   busy               digits being scanned
//   done               one-cycle result-valid pulse
//   res                outcome of the selected relation
//   eq, lt, gt         raw relation flags, held until the next completed compare
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [2:0]       sel,
    input  logic             signed_cmp,
    output logic             busy,
    output logic             done,
    output logic             res,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_sel;
    logic [IDXW-1:0]  r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_res;
    logic             r_eq;
    logic             r_lt;
    logic             r_gt;

    logic [1:0]       w_state_nxt;
    logic             w_accept;
    logic             w_load;
    logic [IDXW-1:0]  w_idx_nxt;
    logic             w_eq_nxt;
    logic             w_lt_nxt;
    logic             w_gt_nxt;
    logic             w_res_nxt;
    logic [DIGIT-1:0] w_sa;
    logic [DIGIT-1:0] w_sb;
    logic [WIDTH-1:0] w_bias;

    // MSB flip maps two's-complement order onto unsigned order
    assign w_bias = {signed_cmp, {(WIDTH-1){1'b0}}};

    // Digit currently under inspection
    assign w_sa = r_a[r_idx*DIGIT +: DIGIT];
    assign w_sb = r_b[r_idx*DIGIT +: DIGIT];

    // Next-state, scan step and result selection
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_idx_nxt   = r_idx;
        w_eq_nxt    = r_eq;
        w_lt_nxt    = r_lt;
        w_gt_nxt    = r_gt;
        w_res_nxt   = r_res;

        case (r_state)
            IDLE, FIN: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SCAN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SCAN: begin
                if (w_sa != w_sb) begin
                    // First differing digit decides the order
                    w_load      = 1'b1;
                    w_eq_nxt    = 1'b0;
                    w_lt_nxt    = (w_sa < w_sb);
                    w_gt_nxt    = (w_sa > w_sb);
                    w_state_nxt = FIN;
                end else if (r_idx == '0) begin
                    w_load      = 1'b1;
                    w_eq_nxt    = 1'b1;
                    w_lt_nxt    = 1'b0;
                    w_gt_nxt    = 1'b0;
                    w_state_nxt = FIN;
                end else begin
                    w_idx_nxt   = r_idx - IDXW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        case (r_sel)
            3'b000:  w_res_nxt = w_eq_nxt;
            3'b001:  w_res_nxt = !w_eq_nxt;
            3'b010:  w_res_nxt = w_lt_nxt;
            3'b011:  w_res_nxt = w_lt_nxt | w_eq_nxt;
            3'b100:  w_res_nxt = w_gt_nxt;
            3'b101:  w_res_nxt = w_gt_nxt | w_eq_nxt;
            default: w_res_nxt = 1'b0;
        endcase
    end

    // State, captured operands and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == SCAN);
            r_done  <= (w_state_nxt == FIN);
            if (w_accept) begin
                r_a   <= opA ^ w_bias;
                r_b   <= opB ^ w_bias;
                r_sel <= sel;
                r_idx <= IDXW'(NDIG - 1);
            end else begin
                r_idx <= w_idx_nxt;
            end
            if (w_load) begin
                r_eq  <= w_eq_nxt;
                r_lt  <= w_lt_nxt;
                r_gt  <= w_gt_nxt;
                r_res <= w_res_nxt;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign res  = r_res;
    assign eq   = r_eq;
    assign lt   = r_lt;
    assign gt   = r_gt;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (WIDTH=16, DIGIT=4).
// Stimulus pushes the reference-model result and its expected done cycle;
// a negedge monitor pops on every done pulse and checks that flags hold
// between completions.
module tb_serial_magnitude_comparator;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIGIT = 4;
    localparam int unsigned NDIG  = WIDTH / DIGIT;

    typedef struct {
        logic        res;
        logic        eq;
        logic        lt;
        logic        gt;
        int unsigned done_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] opA = '0;
    logic [WIDTH-1:0] opB = '0;
    logic [2:0]       sel = '0;
    logic             signed_cmp = 1'b0;
    logic             busy, done, res, eq, lt, gt;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    exp_t        q[$];
    exp_t        last;

    serial_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .opA        (opA),
        .opB        (opB),
        .sel        (sel),
        .signed_cmp (signed_cmp),
        .busy       (busy),
        .done       (done),
        .res        (res),
        .eq         (eq),
        .lt         (lt),
        .gt         (gt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic compare; digits examined follow from the
    // highest differing bit position.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [2:0] s, input logic sg,
                                  output exp_t e, output int d);
        logic [WIDTH-1:0] x;
        int p;
        if (sg) begin
            e.lt = ($signed(a) < $signed(b));
            e.gt = ($signed(a) > $signed(b));
        end else begin
            e.lt = (a < b);
            e.gt = (a > b);
        end
        e.eq = (a == b);
        x = a ^ b;
        p = -1;
        for (int i = 0; i < int'(WIDTH); i++) if (x[i]) p = i;
        d = (p < 0) ? int'(NDIG) : int'(NDIG) - p / int'(DIGIT);
        case (s)
            3'b000:  e.res = e.eq;
            3'b001:  e.res = !e.eq;
            3'b010:  e.res = e.lt;
            3'b011:  e.res = e.lt | e.eq;
            3'b100:  e.res = e.gt;
            3'b101:  e.res = e.gt | e.eq;
            default: e.res = 1'b0;
        endcase
        e.done_cyc = 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one compare; caller guarantees the DUT is idle or in its done cycle.
    // Returns in the done cycle with start low unless b2b leaves it to the caller.
    task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2:0] s, input logic sg,
                           input bit junk, input bit b2b, input int idle_after);
        exp_t e;
        int   d;
        model(a, b, s, sg, e, d);
        opA = a; opB = b; sel = s; signed_cmp = sg; start = 1'b1;
        step();
        e.done_cyc = cyc + d;
        q.push_back(e);
        chk("busy_after_accept", 32'(busy), 32'(1));
        start = 1'b0;
        while (cyc < e.done_cyc) begin
            if (junk) begin
                start = 1'b1;
                opA = WIDTH'($urandom);
                opB = WIDTH'($urandom);
                sel = 3'($urandom);
                signed_cmp = 1'($urandom);
            end
            step();
        end
        start = 1'b0;
        if (!b2b) repeat (idle_after) step();
    endtask

    // Monitor: pop on done, otherwise the flags must hold
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("res", 32'(res), 32'(e.res));
                    chk("eq",  32'(eq),  32'(e.eq));
                    chk("lt",  32'(lt),  32'(e.lt));
                    chk("gt",  32'(gt),  32'(e.gt));
                    chk("onehot_flags", 32'(eq) + 32'(lt) + 32'(gt), 32'(1));
                    chk("busy_in_done", 32'(busy), 32'(0));
                    last = e;
                end
            end else begin
                chk("hold_flags", {28'd0, res, eq, lt, gt},
                    {28'd0, last.res, last.eq, last.lt, last.gt});
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [WIDTH-1:0] a, b;
        int unsigned c0;
        last = '{res: 1'b0, eq: 1'b0, lt: 1'b0, gt: 1'b0, done_cyc: 0};

        // Reset, with start held high to show it is ignored under reset
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        chk("rst_outputs", {26'd0, busy, done, res, eq, lt, gt}, 32'd0);
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;
        chk("idle_after_rst", {30'd0, busy, done}, 32'd0);
        step();

        // Directed cases
        run_cmp(16'h1234, 16'h1240, 3'b010, 1'b0, 1'b0, 1'b0, 1);
        run_cmp(16'hBEEF, 16'hBEEF, 3'b000, 1'b0, 1'b0, 1'b0, 1);
        run_cmp(16'hBEEF, 16'hBEEF, 3'b001, 1'b0, 1'b0, 1'b0, 1);
        run_cmp(16'hFFFF, 16'h0001, 3'b010, 1'b1, 1'b0, 1'b0, 1);
        run_cmp(16'hFFFF, 16'h0001, 3'b010, 1'b0, 1'b0, 1'b0, 1);
        run_cmp(16'h0000, 16'hFFFF, 3'b010, 1'b0, 1'b1, 1'b1, 0);
        run_cmp(16'h0001, 16'h0002, 3'b110, 1'b0, 1'b1, 1'b1, 0);
        run_cmp(16'h8000, 16'h7FFF, 3'b101, 1'b1, 1'b0, 1'b0, 2);

        // Reset after edge 2 of an equal-operand compare aborts it
        opA = 16'h5555; opB = 16'h5555; sel = 3'b000; signed_cmp = 1'b0; start = 1'b1;
        step();
        c0 = cyc;
        start = 1'b0;
        while (cyc < c0 + 2) step();
        rst_n = 1'b0;
        step();
        void'(q.pop_back());
        last = '{res: 1'b0, eq: 1'b0, lt: 1'b0, gt: 1'b0, done_cyc: 0};
        chk("abort_outputs", {26'd0, busy, done, res, eq, lt, gt}, 32'd0);
        rst_n = 1'b1;
        repeat (4) step();
        chk("abort_no_done", 32'(q.size()), 32'd0);

        // Randomized compares
        for (int n = 0; n < 250; n++) begin
            a = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: b = WIDTH'($urandom);
            endcase
            run_cmp(a, b, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    1'($urandom), $urandom_range(0, 2));
        end

        repeat (6) step();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
